// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Control FSM for the multi-cycle RV32 core.  Every instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and this block raises the stage
// enables for the PC, IR, ALU, data memory and register file along the way.
// It also watches the instruction/data memory ready handshakes with a
// bounded wait, traps on illegal opcodes or memory timeouts, and counts
// retired instructions.
//
// Parameters
//   MEM_TIMEOUT  cycles a memory request may wait with ready low (2..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   opcode        instr[6:0] from the IR, valid from DECODE onward
//   imem_ready    instruction memory data valid (looked at in FETCH)
//   dmem_ready    data memory access complete (looked at in MEM)
//   branch_taken  ALU compare result (looked at in EXEC for branches)
//   imem_req      instruction fetch request
//   ir_we         IR load strobe
//   dmem_req      data memory request
//   dmem_we       data memory write (store)
//   dmem_rd       data memory read (load)
//   alu_op        00 add, 01 branch compare, 10 arithmetic
//   alu_src       1 selects the immediate as operand B
//   wb_sel        1 writes back memory data, 0 writes back the ALU result
//   rf_we         register file write enable
//   pc_we         PC update strobe
//   pc_sel        1 branch target, 0 PC+4
//   retire        one-cycle pulse when an instruction completes
//   retired_cnt   number of retired instructions (wraps)
//   trap          sticky error flag
//   trap_cause    01 illegal opcode, 10 imem timeout, 11 dmem timeout
//   state         debug view of the FSM state
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             dmem_rd,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             wb_sel,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL   = 3'd0,
    CLS_BRANCH    = 3'd1,
    CLS_ARITH_IMM = 3'd2,
    CLS_ARITH_REG = 3'd3,
    CLS_LOAD      = 3'd4,
    CLS_STORE     = 3'd5
  } cls_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_ARITH  = 2'b10;

  // The wait counter value seen in the last permitted wait cycle; one more
  // cycle with ready low makes the count reach MEM_TIMEOUT and traps.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t            state_q, next_state;
  cls_t              cls_q, dec_cls;
  logic [7:0]        wait_cnt;
  logic              wait_inc, wait_clr, latch_cls;
  logic              trap_q;
  logic [1:0]        cause_q, next_cause;
  logic [CNT_W-1:0]  cnt_q;

  // Opcode classification.  Only the five supported major opcodes with the
  // mandatory 11 low bits are legal; everything else falls into
  // CLS_ILLEGAL so DECODE can send the FSM to TRAP.
  always_comb begin
    dec_cls = CLS_ILLEGAL;
    if (opcode[1:0] == 2'b11) begin
      case (opcode[6:2])
        5'b11000: dec_cls = CLS_BRANCH;
        5'b00100: dec_cls = CLS_ARITH_IMM;
        5'b01100: dec_cls = CLS_ARITH_REG;
        5'b00000: dec_cls = CLS_LOAD;
        5'b01000: dec_cls = CLS_STORE;
        default:  dec_cls = CLS_ILLEGAL;
      endcase
    end
  end

  // Next-state and strobe logic.  Strobes depend on the registered state,
  // the registered class and the live ready/branch inputs.  Every output is
  // defaulted low first, so a state only raises what it needs.  While
  // rst_n is low everything is forced low, which keeps the reset cycle
  // quiet and stops a pending retire from being counted when an
  // instruction is abandoned by reset.
  always_comb begin
    next_state = state_q;
    next_cause = cause_q;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    latch_cls  = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_rd    = 1'b0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    wb_sel     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    retire     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we      = 1'b1;
          wait_clr   = 1'b1;
          next_state = ST_DECODE;
        end else begin
          wait_inc = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            next_state = ST_TRAP;
            next_cause = CAUSE_IMEM;
          end
        end
      end

      ST_DECODE: begin
        latch_cls = 1'b1;
        wait_clr  = 1'b1;
        if (dec_cls == CLS_ILLEGAL) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end else begin
          next_state = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            alu_op     = ALU_BRANCH;
            pc_we      = 1'b1;
            pc_sel     = branch_taken;
            retire     = 1'b1;
            next_state = ST_FETCH;
          end
          CLS_ARITH_IMM: begin
            alu_op     = ALU_ARITH;
            alu_src    = 1'b1;
            next_state = ST_WB;
          end
          CLS_ARITH_REG: begin
            alu_op     = ALU_ARITH;
            next_state = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op     = ALU_ADD;
            alu_src    = 1'b1;
            next_state = ST_MEM;
          end
          default: begin
            next_state = ST_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_rd  = (cls_q == CLS_LOAD);
        dmem_we  = (cls_q == CLS_STORE);
        alu_op   = ALU_ADD;
        alu_src  = 1'b1;
        if (dmem_ready) begin
          wait_clr = 1'b1;
          if (cls_q == CLS_STORE) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end else begin
          wait_inc = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            next_state = ST_TRAP;
            next_cause = CAUSE_DMEM;
          end
        end
      end

      ST_WB: begin
        rf_we      = 1'b1;
        wb_sel     = (cls_q == CLS_LOAD);
        pc_we      = 1'b1;
        pc_sel     = 1'b0;
        retire     = 1'b1;
        next_state = ST_FETCH;
      end

      ST_TRAP: begin
        next_state = ST_TRAP;
      end

      default: begin
        next_state = ST_FETCH;
      end
    endcase

    if (!rst_n) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      dmem_rd  = 1'b0;
      alu_op   = ALU_ADD;
      alu_src  = 1'b0;
      wb_sel   = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      retire   = 1'b0;
    end
  end

  // State register plus the bookkeeping that rides along with it: the
  // latched opcode class, the memory wait counter, the sticky trap flag and
  // its cause, and the retired-instruction counter.  The wait counter is
  // also cleared whenever a handshake completes so a slow data access never
  // eats into the next fetch's allowance.  The cause is captured only on
  // the transition into TRAP and held from then on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      cls_q    <= CLS_ILLEGAL;
      wait_cnt <= 8'd0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      state_q <= next_state;
      if (latch_cls) begin
        cls_q <= dec_cls;
      end
      if (wait_clr) begin
        wait_cnt <= 8'd0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ((next_state == ST_TRAP) && (state_q != ST_TRAP)) begin
        trap_q  <= 1'b1;
        cause_q <= next_cause;
      end
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign retired_cnt = cnt_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Bench for multicycle_sequencer with MEM_TIMEOUT=16 and CNT_W=4.  A table
// of one-cycle vectors walks ADDI, BEQ taken/not taken, ADD, SW and a LW
// with a stalled data memory; hand-written sequences then cover the
// illegal-opcode trap, both memory timeouts, the ready/timeout tie, reset
// in the middle of a store and counter wrap.
//
// Inputs are driven on the falling edge and outputs are sampled 1ns later,
// well away from the rising edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ILL  = 7'b1111111;

  // Packed strobe layout:
  // [15]imem_req [14]ir_we [13]dmem_req [12]dmem_we [11]dmem_rd
  // [10:9]alu_op [8]alu_src [7]wb_sel [6]rf_we [5]pc_we [4]pc_sel
  // [3]retire [2]trap [1:0]trap_cause
  localparam logic [15:0] S_IMEM  = 16'h8000;
  localparam logic [15:0] S_IR    = 16'h4000;
  localparam logic [15:0] S_DREQ  = 16'h2000;
  localparam logic [15:0] S_DWE   = 16'h1000;
  localparam logic [15:0] S_DRD   = 16'h0800;
  localparam logic [15:0] S_ALUAR = 16'h0400;
  localparam logic [15:0] S_ALUBR = 16'h0200;
  localparam logic [15:0] S_ASRC  = 16'h0100;
  localparam logic [15:0] S_WBSEL = 16'h0080;
  localparam logic [15:0] S_RFWE  = 16'h0040;
  localparam logic [15:0] S_PCWE  = 16'h0020;
  localparam logic [15:0] S_PCSEL = 16'h0010;
  localparam logic [15:0] S_RET   = 16'h0008;
  localparam logic [15:0] S_TRAP  = 16'h0004;
  localparam logic [15:0] C_ILL   = 16'h0001;
  localparam logic [15:0] C_IMEM  = 16'h0002;
  localparam logic [15:0] C_DMEM  = 16'h0003;

  typedef struct {
    logic        rst_n;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        branch_taken;
    logic [2:0]  exp_state;
    logic [15:0] exp_strobes;
    logic [3:0]  exp_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_rd;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        wb_sel;
  logic        rf_we;
  logic        pc_we;
  logic        pc_sel;
  logic        retire;
  logic [3:0]  retired_cnt;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [15:0] got_strobes;

  int errors;
  int checks;
  vec_t vecs[$];

  multicycle_sequencer #(
    .MEM_TIMEOUT(16),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .branch_taken(branch_taken),
    .imem_req(imem_req),
    .ir_we(ir_we),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_rd(dmem_rd),
    .alu_op(alu_op),
    .alu_src(alu_src),
    .wb_sel(wb_sel),
    .rf_we(rf_we),
    .pc_we(pc_we),
    .pc_sel(pc_sel),
    .retire(retire),
    .retired_cnt(retired_cnt),
    .trap(trap),
    .trap_cause(trap_cause),
    .state(state)
  );

  assign got_strobes = {imem_req, ir_we, dmem_req, dmem_we, dmem_rd, alu_op,
                        alu_src, wb_sel, rf_we, pc_we, pc_sel, retire, trap,
                        trap_cause};

  // 10ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case something stalls the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs on the falling edge and let the
  // combinational outputs settle before anything is sampled.
  task automatic applyStimulus(input logic r, input logic [6:0] op,
                               input logic ir, input logic dr,
                               input logic bt);
    @(negedge clk);
    rst_n        = r;
    opcode       = op;
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = bt;
    #1;
  endtask

  // Compare state, packed strobes and retired count against expectations.
  task automatic checkOutput(input string name, input logic [2:0] es,
                             input logic [15:0] estr, input logic [3:0] ec);
    checks++;
    if (state !== es) begin
      errors++;
      $display("[TB] FAIL %s state: got %0d expected %0d", name, state, es);
    end
    checks++;
    if (got_strobes !== estr) begin
      errors++;
      $display("[TB] FAIL %s strobes: got %h expected %h", name, got_strobes, estr);
    end
    checks++;
    if (retired_cnt !== ec) begin
      errors++;
      $display("[TB] FAIL %s retired_cnt: got %0d expected %0d", name, retired_cnt, ec);
    end
  endtask

  task automatic addVec(input logic r, input logic [6:0] op, input logic ir,
                        input logic dr, input logic bt, input logic [2:0] es,
                        input logic [15:0] estr, input logic [3:0] ec);
    vec_t v;
    v.rst_n        = r;
    v.opcode       = op;
    v.imem_ready   = ir;
    v.dmem_ready   = dr;
    v.branch_taken = bt;
    v.exp_state    = es;
    v.exp_strobes  = estr;
    v.exp_cnt      = ec;
    vecs.push_back(v);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    opcode       = OP_ADDI;
    imem_ready   = 1'b1;
    dmem_ready   = 1'b1;
    branch_taken = 1'b0;

    // Reset cycle: state already FETCH, strobes held low
    addVec(0, OP_ADDI, 1, 1, 0, 3'd0, 16'h0000, 4'd0);
    // ADDI: F D E W
    addVec(1, OP_ADDI, 1, 1, 0, 3'd0, S_IMEM | S_IR, 4'd0);
    addVec(1, OP_ADDI, 1, 1, 0, 3'd1, 16'h0000, 4'd0);
    addVec(1, OP_ADDI, 1, 1, 0, 3'd2, S_ALUAR | S_ASRC, 4'd0);
    addVec(1, OP_ADDI, 1, 1, 0, 3'd4, S_RFWE | S_PCWE | S_RET, 4'd0);
    // BEQ taken: F D E
    addVec(1, OP_BEQ, 1, 1, 0, 3'd0, S_IMEM | S_IR, 4'd1);
    addVec(1, OP_BEQ, 1, 1, 0, 3'd1, 16'h0000, 4'd1);
    addVec(1, OP_BEQ, 1, 1, 1, 3'd2, S_ALUBR | S_PCWE | S_PCSEL | S_RET, 4'd1);
    // BEQ not taken
    addVec(1, OP_BEQ, 1, 1, 0, 3'd0, S_IMEM | S_IR, 4'd2);
    addVec(1, OP_BEQ, 1, 1, 0, 3'd1, 16'h0000, 4'd2);
    addVec(1, OP_BEQ, 1, 1, 0, 3'd2, S_ALUBR | S_PCWE | S_RET, 4'd2);
    // ADD (register operand B)
    addVec(1, OP_ADD, 1, 1, 0, 3'd0, S_IMEM | S_IR, 4'd3);
    addVec(1, OP_ADD, 1, 1, 0, 3'd1, 16'h0000, 4'd3);
    addVec(1, OP_ADD, 1, 1, 0, 3'd2, S_ALUAR, 4'd3);
    addVec(1, OP_ADD, 1, 1, 0, 3'd4, S_RFWE | S_PCWE | S_RET, 4'd3);
    // SW with data memory ready: F D E M
    addVec(1, OP_SW, 1, 1, 0, 3'd0, S_IMEM | S_IR, 4'd4);
    addVec(1, OP_SW, 1, 1, 0, 3'd1, 16'h0000, 4'd4);
    addVec(1, OP_SW, 1, 1, 0, 3'd2, S_ASRC, 4'd4);
    addVec(1, OP_SW, 1, 1, 0, 3'd3, S_DREQ | S_DWE | S_ASRC | S_PCWE | S_RET, 4'd4);
    // LW with dmem_ready low for 3 cycles: F D E M M M M W
    addVec(1, OP_LW, 1, 1, 0, 3'd0, S_IMEM | S_IR, 4'd5);
    addVec(1, OP_LW, 1, 1, 0, 3'd1, 16'h0000, 4'd5);
    addVec(1, OP_LW, 1, 1, 0, 3'd2, S_ASRC, 4'd5);
    addVec(1, OP_LW, 1, 0, 0, 3'd3, S_DREQ | S_DRD | S_ASRC, 4'd5);
    addVec(1, OP_LW, 1, 0, 0, 3'd3, S_DREQ | S_DRD | S_ASRC, 4'd5);
    addVec(1, OP_LW, 1, 0, 0, 3'd3, S_DREQ | S_DRD | S_ASRC, 4'd5);
    addVec(1, OP_LW, 1, 1, 0, 3'd3, S_DREQ | S_DRD | S_ASRC, 4'd5);
    addVec(1, OP_LW, 1, 1, 0, 3'd4, S_WBSEL | S_RFWE | S_PCWE | S_RET, 4'd5);
    addVec(1, OP_ADDI, 1, 1, 0, 3'd0, S_IMEM | S_IR, 4'd6);

    $display("[TB] starting, %0d table vectors", vecs.size());

    // Initial reset
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].opcode, vecs[i].imem_ready,
                    vecs[i].dmem_ready, vecs[i].branch_taken);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_state,
                  vecs[i].exp_strobes, vecs[i].exp_cnt);
    end

    // Illegal opcode: trap after DECODE, then silent for 20 cycles
    applyStimulus(0, OP_ILL, 1, 1, 0);
    applyStimulus(1, OP_ILL, 1, 1, 0);
    checkOutput("ill_fetch", 3'd0, S_IMEM | S_IR, 4'd0);
    applyStimulus(1, OP_ILL, 1, 1, 0);
    checkOutput("ill_decode", 3'd1, 16'h0000, 4'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, OP_ADDI, 1, 1, 1);
      checkOutput($sformatf("ill_trap%0d", i), 3'd7, S_TRAP | C_ILL, 4'd0);
    end

    // Instruction memory timeout: 16 wait cycles then TRAP cause 10
    applyStimulus(0, OP_ADDI, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, OP_ADDI, 0, 1, 0);
      checkOutput($sformatf("imem_wait%0d", i), 3'd0, S_IMEM, 4'd0);
    end
    applyStimulus(1, OP_ADDI, 1, 1, 0);
    checkOutput("imem_timeout", 3'd7, S_TRAP | C_IMEM, 4'd0);

    // Ready arriving on the 16th wait cycle wins over the timeout
    applyStimulus(0, OP_ADDI, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, OP_ADDI, 0, 1, 0);
    end
    applyStimulus(1, OP_ADDI, 1, 1, 0);
    checkOutput("tie_fetch", 3'd0, S_IMEM | S_IR, 4'd0);
    applyStimulus(1, OP_ADDI, 1, 1, 0);
    checkOutput("tie_decode", 3'd1, 16'h0000, 4'd0);

    // Data memory timeout on SW: cause 11
    applyStimulus(0, OP_SW, 1, 0, 0);
    applyStimulus(1, OP_SW, 1, 0, 0);
    applyStimulus(1, OP_SW, 1, 0, 0);
    applyStimulus(1, OP_SW, 1, 0, 0);
    checkOutput("dto_exec", 3'd2, S_ASRC, 4'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, OP_SW, 1, 0, 0);
      checkOutput($sformatf("dto_mem%0d", i), 3'd3, S_DREQ | S_DWE | S_ASRC, 4'd0);
    end
    applyStimulus(1, OP_SW, 1, 1, 0);
    checkOutput("dmem_timeout", 3'd7, S_TRAP | C_DMEM, 4'd0);

    // Reset asserted during MEM of a SW: no retire, back to FETCH
    applyStimulus(0, OP_SW, 1, 1, 0);
    applyStimulus(1, OP_SW, 1, 1, 0);
    applyStimulus(1, OP_SW, 1, 1, 0);
    applyStimulus(1, OP_SW, 1, 1, 0);
    applyStimulus(0, OP_SW, 1, 1, 0);
    checkOutput("rst_in_mem", 3'd3, 16'h0000, 4'd0);
    applyStimulus(1, OP_SW, 1, 1, 0);
    checkOutput("rst_after_mem", 3'd0, S_IMEM | S_IR, 4'd0);

    // Counter wrap with CNT_W=4: 16 ADDI retires bring the count back to 0
    applyStimulus(0, OP_ADDI, 1, 1, 0);
    for (int i = 0; i < 15; i++) begin
      repeat (4) applyStimulus(1, OP_ADDI, 1, 1, 0);
    end
    applyStimulus(1, OP_ADDI, 1, 1, 0);
    checkOutput("wrap_15", 3'd0, S_IMEM | S_IR, 4'd15);
    repeat (3) applyStimulus(1, OP_ADDI, 1, 1, 0);
    applyStimulus(1, OP_ADDI, 1, 1, 0);
    checkOutput("wrap_0", 3'd0, S_IMEM | S_IR, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
